// File: rtl/axi_ram_fill_pkg.sv
// Shared types and AXI constants for the axi_ram_fill write engine.
package axi_ram_fill_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AW   = 2'd1,
    ST_W    = 2'd2,
    ST_B    = 2'd3
  } fill_state_t;

  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
  localparam int unsigned AXI_4K_BYTES   = 4096;

endpackage

// File: rtl/axi_ram_fill_burst_calc.sv
// Burst length for the next AW: min(remaining words, max burst, words left in the 4 KB page).
module axi_ram_fill_burst_calc
  import axi_ram_fill_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 12,
  parameter int unsigned STRB_WIDTH    = 4,
  parameter int unsigned MAX_BURST_LEN = 16
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [ADDR_WIDTH:0]   i_remaining,
  output logic [8:0]            o_beats
);

  localparam int unsigned SZ = $clog2(STRB_WIDTH);

  logic [31:0] w_addr_ext;
  logic [31:0] w_page_off;
  logic [31:0] w_room;
  logic [31:0] w_rem;
  logic [31:0] w_min;

  assign w_addr_ext = 32'(i_addr);
  assign w_page_off = w_addr_ext & 32'(AXI_4K_BYTES - 1);
  // Address is word aligned, so the shift is exact.
  assign w_room     = (32'(AXI_4K_BYTES) - w_page_off) >> SZ;
  assign w_rem      = 32'(i_remaining);

  always_comb begin
    w_min = w_rem;
    if (w_min > 32'(MAX_BURST_LEN)) w_min = 32'(MAX_BURST_LEN);
    if (w_min > w_room)             w_min = w_room;
  end

  assign o_beats = 9'(w_min);

endmodule

// File: rtl/axi_ram_fill.sv
// AXI4 write-only fill engine: writes a pattern over a word range in legal INCR bursts.
// Define AXI_RAM_FILL_INCR_EN to write pattern + global word index instead of a constant pattern.
module axi_ram_fill
  import axi_ram_fill_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH    = 12,
  parameter int unsigned STRB_WIDTH    = DATA_WIDTH / 8,
  parameter int unsigned ID_WIDTH      = 8,
  parameter int unsigned MAX_BURST_LEN = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic [DATA_WIDTH-1:0] pattern,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready
);

  localparam int unsigned SZ    = $clog2(STRB_WIDTH);
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  fill_state_t           r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [CNT_W-1:0]      r_remaining, w_remaining_nxt;
  logic [DATA_WIDTH-1:0] r_pattern, w_pattern_nxt;
  logic [8:0]            r_beats, w_beats_nxt;
  logic [8:0]            r_wleft, w_wleft_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_done, w_done_nxt;
  logic                  r_err, w_err_nxt;
  logic                  r_awvalid, w_awvalid_nxt;
  logic [ADDR_WIDTH-1:0] r_awaddr, w_awaddr_nxt;
  logic [7:0]            r_awlen, w_awlen_nxt;
  logic                  r_wvalid, w_wvalid_nxt;
  logic                  r_wlast, w_wlast_nxt;
  logic [DATA_WIDTH-1:0] r_wdata, w_wdata_nxt;
  logic                  r_bready, w_bready_nxt;

  logic [ADDR_WIDTH-1:0] w_base_aligned;
  logic [ADDR_WIDTH-1:0] w_burst_bytes;
  logic [ADDR_WIDTH-1:0] w_addr_adv;
  logic [CNT_W-1:0]      w_rem_adv;
  logic [ADDR_WIDTH-1:0] w_calc_addr;
  logic [CNT_W-1:0]      w_calc_rem;
  logic [8:0]            w_calc_beats;
  logic                  w_w_hs;
  logic                  w_bresp_err;
  logic [DATA_WIDTH-1:0] w_data_first;
  logic [DATA_WIDTH-1:0] w_data_next;

  assign w_base_aligned = base_addr & ~ADDR_WIDTH'(STRB_WIDTH - 1);
  assign w_burst_bytes  = ADDR_WIDTH'(32'(r_beats) << SZ);
  assign w_addr_adv     = r_addr + w_burst_bytes;
  assign w_rem_adv      = r_remaining - CNT_W'(r_beats);
  assign w_w_hs         = r_wvalid && m_axi_wready;
  assign w_bresp_err    = (m_axi_bresp != AXI_RESP_OKAY);

  // Length is needed when leaving IDLE (from the request) and when leaving B (from the advanced pointers).
  assign w_calc_addr = (r_state == ST_IDLE) ? w_base_aligned : w_addr_adv;
  assign w_calc_rem  = (r_state == ST_IDLE) ? word_count     : w_rem_adv;

  axi_ram_fill_burst_calc #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .STRB_WIDTH   (STRB_WIDTH),
    .MAX_BURST_LEN(MAX_BURST_LEN)
  ) u_burst_calc (
    .i_addr     (w_calc_addr),
    .i_remaining(w_calc_rem),
    .o_beats    (w_calc_beats)
  );

`ifdef AXI_RAM_FILL_INCR_EN
  // Global word index, continuing across bursts of one fill.
  logic [DATA_WIDTH-1:0] r_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx <= '0;
    end else if (r_state == ST_IDLE && start) begin
      r_idx <= '0;
    end else if (w_w_hs) begin
      r_idx <= r_idx + DATA_WIDTH'(1);
    end
  end

  assign w_data_first = r_pattern + r_idx;
  assign w_data_next  = r_pattern + r_idx + DATA_WIDTH'(1);
`else
  assign w_data_first = r_pattern;
  assign w_data_next  = r_pattern;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_pattern   <= '0;
      r_beats     <= '0;
      r_wleft     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_awvalid   <= 1'b0;
      r_awaddr    <= '0;
      r_awlen     <= '0;
      r_wvalid    <= 1'b0;
      r_wlast     <= 1'b0;
      r_wdata     <= '0;
      r_bready    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_addr      <= w_addr_nxt;
      r_remaining <= w_remaining_nxt;
      r_pattern   <= w_pattern_nxt;
      r_beats     <= w_beats_nxt;
      r_wleft     <= w_wleft_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
      r_awvalid   <= w_awvalid_nxt;
      r_awaddr    <= w_awaddr_nxt;
      r_awlen     <= w_awlen_nxt;
      r_wvalid    <= w_wvalid_nxt;
      r_wlast     <= w_wlast_nxt;
      r_wdata     <= w_wdata_nxt;
      r_bready    <= w_bready_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_addr_nxt      = r_addr;
    w_remaining_nxt = r_remaining;
    w_pattern_nxt   = r_pattern;
    w_beats_nxt     = r_beats;
    w_wleft_nxt     = r_wleft;
    w_busy_nxt      = r_busy;
    w_done_nxt      = 1'b0;
    w_err_nxt       = r_err;
    w_awvalid_nxt   = r_awvalid;
    w_awaddr_nxt    = r_awaddr;
    w_awlen_nxt     = r_awlen;
    w_wvalid_nxt    = r_wvalid;
    w_wlast_nxt     = r_wlast;
    w_wdata_nxt     = r_wdata;
    w_bready_nxt    = r_bready;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (word_count != '0) begin
            w_state_nxt     = ST_AW;
            w_addr_nxt      = w_base_aligned;
            w_remaining_nxt = word_count;
            w_pattern_nxt   = pattern;
            w_err_nxt       = 1'b0;
            w_busy_nxt      = 1'b1;
            w_awvalid_nxt   = 1'b1;
            w_awaddr_nxt    = w_base_aligned;
            w_awlen_nxt     = 8'(w_calc_beats - 9'd1);
            w_beats_nxt     = w_calc_beats;
          end else begin
            w_done_nxt = 1'b1;
          end
        end
      end

      ST_AW: begin
        if (m_axi_awready) begin
          w_state_nxt   = ST_W;
          w_awvalid_nxt = 1'b0;
          w_wvalid_nxt  = 1'b1;
          w_wdata_nxt   = w_data_first;
          w_wlast_nxt   = (r_beats == 9'd1);
          w_wleft_nxt   = r_beats;
        end
      end

      ST_W: begin
        if (m_axi_wready) begin
          if (r_wlast) begin
            w_state_nxt  = ST_B;
            w_wvalid_nxt = 1'b0;
            w_wlast_nxt  = 1'b0;
            w_bready_nxt = 1'b1;
          end else begin
            w_wleft_nxt = r_wleft - 9'd1;
            w_wlast_nxt = (r_wleft == 9'd2);
            w_wdata_nxt = w_data_next;
          end
        end
      end

      ST_B: begin
        if (m_axi_bvalid) begin
          w_bready_nxt    = 1'b0;
          w_addr_nxt      = w_addr_adv;
          w_remaining_nxt = w_rem_adv;
          if (w_bresp_err) w_err_nxt = 1'b1;
          // A slave error aborts whatever is left of the fill.
          if (w_rem_adv == '0 || w_bresp_err) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
          end else begin
            w_state_nxt   = ST_AW;
            w_awvalid_nxt = 1'b1;
            w_awaddr_nxt  = w_addr_adv;
            w_awlen_nxt   = 8'(w_calc_beats - 9'd1);
            w_beats_nxt   = w_calc_beats;
          end
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign err           = r_err;
  assign m_axi_awid    = '0;
  assign m_axi_awaddr  = r_awaddr;
  assign m_axi_awlen   = r_awlen;
  assign m_axi_awsize  = 3'(SZ);
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_wdata   = r_wdata;
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = r_wlast;
  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_bready  = r_bready;

endmodule
